// File: rtl/cordic_req_arbiter.sv
// Round-robin front end sharing one multi-cycle cordic core between N_REQ requesters.
// Latches the granted angle, pulses core start, returns the result or a watchdog error.
module cordic_req_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 23,
    parameter int TIMEOUT = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clk_en,
    input  logic [N_REQ-1:0]       i_req_valid,
    input  logic [N_REQ*WIDTH-1:0] i_req_theta,
    output logic [N_REQ-1:0]       o_req_ready,
    output logic [N_REQ-1:0]       o_rsp_valid,
    input  logic [N_REQ-1:0]       i_rsp_ready,
    output logic [WIDTH-1:0]       o_rsp_data,
    output logic                   o_rsp_error,
    output logic                   o_core_start,
    output logic [WIDTH-1:0]       o_core_theta,
    output logic                   o_core_clk_en,
    input  logic                   i_core_done,
    input  logic [WIDTH-1:0]       i_core_result
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [GW-1:0]    r_last_grant;
    logic [GW-1:0]    r_grant;
    logic [GW-1:0]    w_gnt;
    logic [GW-1:0]    w_k;
    logic             w_any;
    logic [CW-1:0]    r_wdog;
    logic             r_restart;
    logic [WIDTH-1:0] r_theta;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_error;
    logic             w_wd_exp;
    logic             w_rsp_hs;
    logic [WIDTH-1:0] w_theta [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_theta[i] = i_req_theta[i*WIDTH +: WIDTH];
        end
    end

    // Scan starts one past the last served requester and wraps.
    always_comb begin
        w_any = 1'b0;
        w_gnt = r_last_grant;
        w_k   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_k = GW'((int'(r_last_grant) + i) % N_REQ);
            if (!w_any && i_req_valid[w_k]) begin
                w_any = 1'b1;
                w_gnt = w_k;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        o_req_ready  = '0;
        o_rsp_valid  = '0;
        o_core_start = 1'b0;
        w_wd_exp     = (r_wdog == WD_LAST);
        w_rsp_hs     = i_rsp_ready[r_grant];
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next = S_ISSUE;
                    if (i_clk_en && !reset) o_req_ready[w_gnt] = 1'b1;
                end
            end
            S_ISSUE: begin
                o_core_start = 1'b1;
                w_next       = S_BUSY;
            end
            S_BUSY: begin
                if (i_core_done || w_wd_exp) w_next = S_RESP;
            end
            S_RESP: begin
                o_rsp_valid[r_grant] = 1'b1;
                if (w_rsp_hs) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Core lost its run while disabled: replay the same grant.
        if (r_restart) w_next = S_ISSUE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= GW'(N_REQ - 1);
            r_grant      <= '0;
            r_theta      <= '0;
            r_wdog       <= '0;
            r_restart    <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_error  <= 1'b0;
        end else if (!i_clk_en) begin
            if (r_state == S_BUSY) r_restart <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_restart <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_gnt;
                        r_theta <= w_theta[w_gnt];
                    end
                end
                S_ISSUE: r_wdog <= '0;
                S_BUSY: begin
                    if (!r_restart) begin
                        if (i_core_done) begin
                            r_rsp_data  <= i_core_result;
                            r_rsp_error <= 1'b0;
                        end else begin
                            r_wdog <= r_wdog + CW'(1);
                            if (w_wd_exp) begin
                                r_rsp_data  <= '0;
                                r_rsp_error <= 1'b1;
                            end
                        end
                    end
                end
                S_RESP: begin
                    if (w_rsp_hs) r_last_grant <= r_grant;
                end
                default: ;
            endcase
        end
    end

    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_error   = r_rsp_error;
    assign o_core_theta  = r_theta;
    assign o_core_clk_en = i_clk_en;

endmodule
